cpu64_l1_refill_ctrl: RTL
=========================

Name: cpu64_l1_refill_ctrl

Overview:
Per-L1 miss/refill sequencer. It accepts one miss at a time and picks a victim way through the 8-way PLRU block (invalid-first). If the victim is dirty, it evicts it through the writeback (Release) channel, then issues the Acquire and streams Grant beats into the data array. It closes the miss by updating PLRU state and signalling completion to the pipeline.

Parameters:
INDEX_W, 5, set-index width (SETS = 2**INDEX_W)
TAG_W, 20, tag width
BEATS, 4, Grant data beats per line (power of two, 2..16)
BEAT_W, 2, log2(BEATS)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
miss_valid_i  in  1  miss request
miss_ready_o  out  1  controller idle, can accept
miss_set_i  in  INDEX_W  miss set index
miss_tag_i  in  TAG_W  miss tag
way_valid_i  in  8  valid bits of miss_set_i ways, sampled with the request
way_dirty_i  in  8  dirty bits of miss_set_i ways, sampled with the request
plru_set_o  out  INDEX_W  set index driven to the PLRU block
plru_valid_o  out  8  valid mask driven to the PLRU block
plru_victim_i  in  3  PLRU victim for plru_set_o (combinational)
plru_access_o  out  1  PLRU update strobe
plru_way_o  out  3  way used for the PLRU update
inval_o  out  1  one-cycle pulse: clear valid/dirty of {set_q, victim_q}
wb_valid_o  out  1  writeback request
wb_ready_i  in  1  writeback accepted
wb_set_o  out  INDEX_W  writeback set
wb_way_o  out  3  writeback way
wb_done_i  in  1  ReleaseAck received
acq_valid_o  out  1  Acquire request
acq_ready_i  in  1  Acquire accepted
acq_set_o  out  INDEX_W  Acquire set
acq_tag_o  out  TAG_W  Acquire tag
grant_valid_i  in  1  Grant beat valid (always accepted)
grant_last_i  in  1  final Grant beat
fill_we_o  out  1  data-array write strobe
fill_way_o  out  3  fill way
fill_beat_o  out  BEAT_W  beat index of the current fill write
done_o  out  1  one-cycle pulse: line filled
done_way_o  out  3  way filled (valid with done_o)
err_o  out  1  sticky protocol error

Behaviour:
- Reset: state IDLE; every output 0 except miss_ready_o=1; beat counter 0; err_o 0.
- Handshake rule: a transfer occurs when valid & ready are both high in the same cycle. A raised valid output holds until its transfer.
- IDLE: miss_ready_o=1. On miss_valid_i, latch set_q, tag_q, valid_q, dirty_q, then go to VICTIM.
- plru_set_o = set_q and plru_valid_o = valid_q in every state except IDLE; both are 0 in IDLE.
- VICTIM (1 cycle): latch victim_q = plru_victim_i.
  - If valid_q[victim] & dirty_q[victim], go to WB_REQ.
  - Otherwise go to ACQ_REQ; if valid_q[victim], pulse inval_o this cycle.
- WB_REQ: wb_valid_o=1 with set_q/victim_q. On wb_ready_i, go to WB_WAIT.
- WB_WAIT: on wb_done_i, pulse inval_o and go to ACQ_REQ. wb_done_i outside WB_WAIT sets err_o and is otherwise ignored.
- ACQ_REQ: acq_valid_o=1 with set_q/tag_q. On acq_ready_i, clear the beat counter and go to GRANT.
- GRANT: each grant_valid_i cycle drives fill_we_o=1, fill_way_o=victim_q, fill_beat_o=count, then increments the counter.
  - Beat count BEATS-1 with grant_last_i: go to FINISH.
  - grant_last_i on an earlier beat, or no grant_last_i on beat BEATS-1: set err_o and go to FINISH anyway. The counter wraps to 0.
  - grant_valid_i outside GRANT sets err_o and produces no fill write.
- FINISH (1 cycle): plru_access_o=1, plru_way_o=victim_q, done_o=1, done_way_o=victim_q. Next state IDLE; miss_ready_o goes high the following cycle.
- Latency with clean victim, zero-wait handshakes, BEATS=4: accept at T, VICTIM T+1, ACQ_REQ T+2, beats T+3..T+6, done_o T+7.
- Each miss produces exactly one inval_o, and only when the victim was valid.
- Reset mid-operation: state returns to IDLE immediately. No done_o and no PLRU update for the aborted miss. err_o clears.

Decomposition:
- Shared package cpu64_l1_pkg holds: the FSM state enum (IDLE, VICTIM, WB_REQ, WB_WAIT, ACQ_REQ, GRANT, FINISH; 3-bit) and the NUM_WAYS=8 and WAY_W=3 constants.
- No sub-module. The PLRU block is instantiated alongside this one by the L1 top, not inside it.

Test Plan:
- Cold set: valid=0x00, PLRU victim 5 -> victim_q=0 (invalid-first via PLRU); no wb_valid_o; no inval_o; 4 fill writes way 0 beats 0..3; done_o at T+7; plru_access_o way 0.
- Full clean set: valid=0xFF, dirty=0x00, plru_victim_i=6 -> inval_o in VICTIM; Acquire set/tag match; done_way_o=6.
- Dirty victim: valid=0xFF, dirty=0x40, victim 6, wb_ready_i after 3 cycles, wb_done_i after 5 more -> inval_o on the wb_done cycle; acq_valid_o only after it; done_o follows the 4th beat.
- Backpressure: acq_ready_i low 10 cycles, Grant beats with gaps -> acq_valid_o and acq_tag_o stable; fill_beat_o sequence 0,1,2,3; miss_ready_o=0 throughout.
- Protocol error: grant_last_i on beat 1 -> err_o=1, FINISH entered, done_o pulses; grant_valid_i in IDLE -> err_o stays 1 with no fill_we_o.
- Reset asserted in GRANT after 2 beats -> all outputs 0, miss_ready_o=1, no done_o; next miss completes normally.

Source files
------------

// File: rtl/cpu64_l1_pkg.sv
// Shared L1 definitions: refill sequencer state encoding and way geometry.
package cpu64_l1_pkg;

  localparam int NUM_WAYS = 8;
  localparam int WAY_W    = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VICTIM  = 3'd1,
    WB_REQ  = 3'd2,
    WB_WAIT = 3'd3,
    ACQ_REQ = 3'd4,
    GRANT   = 3'd5,
    FINISH  = 3'd6
  } state_e;

endpackage

// File: rtl/cpu64_l1_refill_ctrl.sv
// Per-L1 miss/refill sequencer: victim selection via the external PLRU,
// optional dirty eviction over Release, Acquire, Grant fill, and completion.
module cpu64_l1_refill_ctrl
  import cpu64_l1_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 20,
  parameter int BEATS   = 4,
  parameter int BEAT_W  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                miss_valid_i,
  output logic                miss_ready_o,
  input  logic [INDEX_W-1:0]  miss_set_i,
  input  logic [TAG_W-1:0]    miss_tag_i,
  input  logic [NUM_WAYS-1:0] way_valid_i,
  input  logic [NUM_WAYS-1:0] way_dirty_i,
  output logic [INDEX_W-1:0]  plru_set_o,
  output logic [NUM_WAYS-1:0] plru_valid_o,
  input  logic [WAY_W-1:0]    plru_victim_i,
  output logic                plru_access_o,
  output logic [WAY_W-1:0]    plru_way_o,
  output logic                inval_o,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [INDEX_W-1:0]  wb_set_o,
  output logic [WAY_W-1:0]    wb_way_o,
  input  logic                wb_done_i,
  output logic                acq_valid_o,
  input  logic                acq_ready_i,
  output logic [INDEX_W-1:0]  acq_set_o,
  output logic [TAG_W-1:0]    acq_tag_o,
  input  logic                grant_valid_i,
  input  logic                grant_last_i,
  output logic                fill_we_o,
  output logic [WAY_W-1:0]    fill_way_o,
  output logic [BEAT_W-1:0]   fill_beat_o,
  output logic                done_o,
  output logic [WAY_W-1:0]    done_way_o,
  output logic                err_o
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_e              state_q;
  logic [BEAT_W-1:0]   cnt_q;
  logic                err_q;
  logic [INDEX_W-1:0]  set_q;
  logic [TAG_W-1:0]    tag_q;
  logic [NUM_WAYS-1:0] valid_q;
  logic [NUM_WAYS-1:0] dirty_q;
  logic [WAY_W-1:0]    victim_q;

  logic victim_valid;
  logic victim_dirty;
  logic beat_is_last;
  logic grant_fire;
  logic grant_end;
  logic proto_err;

  // The PLRU answer is combinational on plru_set_o/plru_valid_o, so the
  // victim's status is looked up in the same cycle it is latched.
  assign victim_valid = valid_q[plru_victim_i];
  assign victim_dirty = dirty_q[plru_victim_i];
  assign beat_is_last = (cnt_q == LAST_BEAT);
  assign grant_fire   = (state_q == GRANT) && grant_valid_i;
  // Either a correct last beat or a protocol slip ends the fill; errors still close the miss.
  assign grant_end    = grant_fire && (beat_is_last || grant_last_i);
  assign proto_err    = (wb_done_i && (state_q != WB_WAIT))
                     || (grant_valid_i && (state_q != GRANT))
                     || (grant_fire && (beat_is_last != grant_last_i));

  // Control FSM: sequencing, beat counter and sticky protocol error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (proto_err) err_q <= 1'b1;
      unique case (state_q)
        IDLE:    if (miss_valid_i) state_q <= VICTIM;
        VICTIM:  state_q <= (victim_valid && victim_dirty) ? WB_REQ : ACQ_REQ;
        WB_REQ:  if (wb_ready_i) state_q <= WB_WAIT;
        WB_WAIT: if (wb_done_i) state_q <= ACQ_REQ;
        ACQ_REQ: begin
          if (acq_ready_i) begin
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (grant_fire) begin
            cnt_q <= cnt_q + 1'b1;
            if (grant_end) state_q <= FINISH;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Miss context capture; only observed through state-qualified outputs, so no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && miss_valid_i) begin
      set_q   <= miss_set_i;
      tag_q   <= miss_tag_i;
      valid_q <= way_valid_i;
      dirty_q <= way_dirty_i;
    end
    if (state_q == VICTIM) victim_q <= plru_victim_i;
  end

  assign miss_ready_o  = (state_q == IDLE);
  assign plru_set_o    = (state_q == IDLE) ? '0 : set_q;
  assign plru_valid_o  = (state_q == IDLE) ? '0 : valid_q;

  // A valid victim is invalidated once: at selection if clean, at ReleaseAck if dirty.
  assign inval_o       = ((state_q == VICTIM) && victim_valid && !victim_dirty)
                      || ((state_q == WB_WAIT) && wb_done_i);

  assign wb_valid_o    = (state_q == WB_REQ);
  assign wb_set_o      = wb_valid_o ? set_q : '0;
  assign wb_way_o      = wb_valid_o ? victim_q : '0;

  assign acq_valid_o   = (state_q == ACQ_REQ);
  assign acq_set_o     = acq_valid_o ? set_q : '0;
  assign acq_tag_o     = acq_valid_o ? tag_q : '0;

  assign fill_we_o     = grant_fire;
  assign fill_way_o    = grant_fire ? victim_q : '0;
  assign fill_beat_o   = grant_fire ? cnt_q : '0;

  assign done_o        = (state_q == FINISH);
  assign done_way_o    = done_o ? victim_q : '0;
  assign plru_access_o = done_o;
  assign plru_way_o    = done_o ? victim_q : '0;

  assign err_o         = err_q;

endmodule
